// File: rtl/mdu_ex_if.sv
// Operand/control and result bundle between the EX stage and the multiply/divide unit.
interface mdu_ex_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  Op;
  logic        Start;
  logic        IntReq;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output A, B, Op, Start, IntReq,
    input  Busy, HI, LO
  );

  modport slave (
    input  A, B, Op, Start, IntReq,
    output Busy, HI, LO
  );
endinterface

// File: rtl/mdu_ex.sv
// EX-stage multiply/divide unit: holds HI/LO and models fixed mult/div latency.
// The result is computed at accept and parked in pending registers until the count expires.
module mdu_ex #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic     Clk,
  input logic     Reset,
  mdu_ex_if.slave bus
);

  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  typedef enum logic {StIdle, StRun} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] hi_p_q, hi_p_d;
  logic [31:0] lo_p_q, lo_p_d;
  logic        wr_p_q, wr_p_d;

  logic        accept;
  logic        a_neg, b_neg;
  logic [63:0] prod;
  logic [31:0] abs_a, abs_b, divisor, q_u, r_u, quot, rem;

  // Signed variants fold into one datapath by sign-extending or taking magnitudes.
  always_comb begin
    a_neg   = ((bus.Op == OpMult) || (bus.Op == OpDiv)) && bus.A[31];
    b_neg   = ((bus.Op == OpMult) || (bus.Op == OpDiv)) && bus.B[31];
    prod    = {{32{a_neg}}, bus.A} * {{32{b_neg}}, bus.B};
    abs_a   = a_neg ? (32'd0 - bus.A) : bus.A;
    abs_b   = b_neg ? (32'd0 - bus.B) : bus.B;
    divisor = (bus.B == 32'd0) ? 32'd1 : abs_b;
    q_u     = abs_a / divisor;
    r_u     = abs_a % divisor;
    quot    = (a_neg ^ b_neg) ? (32'd0 - q_u) : q_u;
    rem     = a_neg ? (32'd0 - r_u) : r_u;
  end

  assign accept = bus.Start && !bus.IntReq && (state_q == StIdle) &&
                  (bus.Op != 3'd0) && (bus.Op != 3'd7);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    hi_p_d  = hi_p_q;
    lo_p_d  = lo_p_q;
    wr_p_d  = wr_p_q;
    if (state_q == StRun) begin
      if (cnt_q == 4'd0) begin
        state_d = StIdle;
        if (wr_p_q) begin
          hi_d = hi_p_q;
          lo_d = lo_p_q;
        end
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end else if (accept) begin
      case (bus.Op)
        OpMult, OpMultu: begin
          {hi_p_d, lo_p_d} = prod;
          wr_p_d  = 1'b1;
          cnt_d   = 4'(MULT_CYCLES - 1);
          state_d = StRun;
        end
        OpDiv, OpDivu: begin
          hi_p_d  = rem;
          lo_p_d  = quot;
          wr_p_d  = (bus.B != 32'd0);
          cnt_d   = 4'(DIV_CYCLES - 1);
          state_d = StRun;
        end
        OpMthi:  hi_d = bus.A;
        OpMtlo:  lo_d = bus.A;
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      hi_p_q  <= 32'd0;
      lo_p_q  <= 32'd0;
      wr_p_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      hi_p_q  <= hi_p_d;
      lo_p_q  <= lo_p_d;
      wr_p_q  <= wr_p_d;
    end
  end

  assign bus.Busy = (state_q == StRun);
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mdu_ex.sv
// Directed bench for mdu_ex: table of single ops plus hand sequences for flush/reset corners.
module tb_mdu_ex;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [31:0] m_hi, m_lo;

  mdu_ex_if bus ();

  mdu_ex #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          busy;
    bit          wr_hi;
    bit          wr_lo;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vec [12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic irq);
    bus.Op = op; bus.A = a; bus.B = b; bus.Start = 1'b1; bus.IntReq = irq;
    step();
    bus.Start = 1'b0; bus.IntReq = 1'b0; bus.Op = 3'd0;
  endtask

  // Counts Busy cycles (issue already advanced into cycle k+1), checking HI/LO hold meanwhile.
  task automatic wait_done(input string name, output int cycles);
    cycles = 0;
    while (bus.Busy === 1'b1 && cycles < 40) begin
      chk({name, " hold HI"}, bus.HI, m_hi);
      chk({name, " hold LO"}, bus.LO, m_lo);
      step();
      cycles++;
    end
  endtask

  initial begin
    int cyc;
    vec[0]  = '{3'd1, 32'hFFFFFFFD, 32'd5,        5,  1, 1, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vec[1]  = '{3'd2, 32'hFFFFFFFF, 32'd2,        5,  1, 1, 32'h00000001, 32'hFFFFFFFE};
    vec[2]  = '{3'd3, 32'hFFFFFFF9, 32'd2,        10, 1, 1, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vec[3]  = '{3'd4, 32'd7,        32'd0,        10, 0, 0, 32'h0,        32'h0};
    vec[4]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 10, 1, 1, 32'h00000000, 32'h80000000};
    vec[5]  = '{3'd4, 32'hFFFFFFFF, 32'd10,       10, 1, 1, 32'h00000005, 32'h19999999};
    vec[6]  = '{3'd5, 32'h12345678, 32'd0,        0,  1, 0, 32'h12345678, 32'h0};
    vec[7]  = '{3'd6, 32'h9ABCDEF0, 32'd0,        0,  0, 1, 32'h0,        32'h9ABCDEF0};
    vec[8]  = '{3'd3, 32'd7,        32'hFFFFFFFE, 10, 1, 1, 32'h00000001, 32'hFFFFFFFD};
    vec[9]  = '{3'd1, 32'h00010000, 32'h00010000, 5,  1, 1, 32'h00000001, 32'h00000000};
    vec[10] = '{3'd7, 32'h55555555, 32'd3,        0,  0, 0, 32'h0,        32'h0};
    vec[11] = '{3'd3, 32'hFFFFFFF9, 32'hFFFFFFFE, 10, 1, 1, 32'hFFFFFFFF, 32'h00000003};

    bus.A = '0; bus.B = '0; bus.Op = '0; bus.Start = 1'b0; bus.IntReq = 1'b0;
    step(); step();
    rst_n = 1'b1;
    chk("reset Busy", {31'd0, bus.Busy}, 32'd0);
    chk("reset HI", bus.HI, 32'd0);
    chk("reset LO", bus.LO, 32'd0);
    m_hi = 32'd0; m_lo = 32'd0;

    // Each vector starts in the cycle Busy drops, exercising back-to-back acceptance.
    for (int i = 0; i < 12; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      issue(vec[i].op, vec[i].a, vec[i].b, 1'b0);
      wait_done(nm, cyc);
      chk({nm, " busy cycles"}, cyc, vec[i].busy);
      if (vec[i].wr_hi) m_hi = vec[i].hi;
      if (vec[i].wr_lo) m_lo = vec[i].lo;
      chk({nm, " HI"}, bus.HI, m_hi);
      chk({nm, " LO"}, bus.LO, m_lo);
    end

    // mthi then mtlo on consecutive cycles; Busy must never rise.
    issue(3'd5, 32'hCAFEF00D, 32'd0, 1'b0);
    chk("mthi HI next cycle", bus.HI, 32'hCAFEF00D);
    chk("mthi Busy", {31'd0, bus.Busy}, 32'd0);
    issue(3'd6, 32'h0BADBEEF, 32'd0, 1'b0);
    chk("mtlo LO next cycle", bus.LO, 32'h0BADBEEF);
    chk("mtlo HI kept", bus.HI, 32'hCAFEF00D);
    chk("mtlo Busy", {31'd0, bus.Busy}, 32'd0);
    m_hi = 32'hCAFEF00D; m_lo = 32'h0BADBEEF;

    // Flushed ops have no effect.
    issue(3'd5, 32'h11111111, 32'd0, 1'b1);
    chk("flushed mthi HI", bus.HI, m_hi);
    issue(3'd1, 32'd3, 32'd4, 1'b1);
    chk("flushed mult Busy", {31'd0, bus.Busy}, 32'd0);
    step(); step();
    chk("flushed mult HI", bus.HI, m_hi);
    chk("flushed mult LO", bus.LO, m_lo);

    // IntReq in RUN cycle 2 and a stray Start in RUN are both ignored; result lands at k+6.
    issue(3'd2, 32'd6, 32'd7, 1'b0);            // now in cycle k+1
    bus.Start = 1'b1; bus.Op = 3'd5; bus.A = 32'hDEADDEAD;
    step();                                     // cycle k+2
    bus.Start = 1'b0; bus.Op = 3'd0; bus.IntReq = 1'b1;
    step();                                     // cycle k+3
    bus.IntReq = 1'b0;
    step(); step();                             // cycle k+5
    chk("irq run Busy k+5", {31'd0, bus.Busy}, 32'd1);
    chk("irq run HI held", bus.HI, m_hi);
    step();                                     // cycle k+6
    chk("irq run Busy k+6", {31'd0, bus.Busy}, 32'd0);
    chk("irq run HI", bus.HI, 32'd0);
    chk("irq run LO", bus.LO, 32'd42);
    m_hi = 32'd0; m_lo = 32'd42;

    // Reset during RUN cycle 4 abandons the divide.
    issue(3'd4, 32'd100, 32'd3, 1'b0);          // cycle k+1
    step(); step(); step();                     // cycle k+4
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("run reset Busy", {31'd0, bus.Busy}, 32'd0);
    chk("run reset HI", bus.HI, 32'd0);
    chk("run reset LO", bus.LO, 32'd0);
    for (int i = 0; i < 12; i++) step();
    chk("abandoned HI", bus.HI, 32'd0);
    chk("abandoned LO", bus.LO, 32'd0);
    chk("abandoned Busy", {31'd0, bus.Busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
